ram_master: RTL

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master_pkg.sv | 22 ++
 rtl/ram_master.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared defaults and enumerations for the RAM burst master.
//   ADDR_WIDTH_DEFAULT / DATA_WIDTH_DEFAULT : default RAM address / data widths
//   op_e    : burst direction carried on cmd_op
//   state_e : burst controller states
package ram_master_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 16;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_ADDR = 2'd2,
    READ_DATA = 2'd3
  } state_e;

endpackage

// File: rtl/ram_master.sv
// ram_master: turns burst commands into single-port RAM accesses.
//
// Ports
//   clk, rst_p                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_addr, cmd_len        direction, start address, beats minus one
//   wr_valid/wr_ready/wr_data        write-data stream (accepted in WRITE)
//   rd_valid/rd_ready/rd_data        read-data stream (offered in READ_DATA)
//   ram_addr/ram_data_in/ram_rdn_wr  registered RAM controls (ram_rdn_wr: 0 read, 1 write)
//   ram_data_out                     RAM read data, combinational w.r.t. ram_addr
//   busy                             high while a burst is active
//   err                              one-cycle pulse on a rejected command
//
// Build option
//   RAM_MASTER_WRAP_ERR_EN : when defined, a command whose burst would run past
//   the top of the address space is consumed, flagged on err and not executed.
//   When undefined err is tied low and bursts wrap modulo 2**ADDR_WIDTH.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_rdn_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  err
);

  state_e                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   remaining;
  logic                    cmd_fire, wr_fire, rd_fire, last_beat, wrap_bad;

  // Ready signals are gated by rst_p so nothing is accepted at a reset edge
  // and cmd_ready reads 0 for the whole reset interval.
  assign cmd_ready = (state == IDLE)  && !rst_p;
  assign wr_ready  = (state == WRITE) && !rst_p;
  assign busy      = (state != IDLE);

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid  && wr_ready;
  assign rd_fire   = rd_valid  && rd_ready;
  assign last_beat = (remaining == '0);

`ifdef RAM_MASTER_WRAP_ERR_EN
  // Carry out of start+len means the burst would cross the top address.
  logic [ADDR_WIDTH:0] end_addr;
  assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign wrap_bad = end_addr[ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst_p) err <= 1'b0;
    else       err <= cmd_fire && wrap_bad;
  end
`else
  assign wrap_bad = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire && !wrap_bad)
          state_nxt = (op_e'(cmd_op) == OP_WRITE) ? WRITE : READ_ADDR;
      end
      WRITE: begin
        if (wr_fire && last_beat) state_nxt = IDLE;
      end
      READ_ADDR: state_nxt = READ_DATA;
      READ_DATA: begin
        if (rd_fire) state_nxt = last_beat ? IDLE : READ_ADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_rdn_wr  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ram_rdn_wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            ram_addr    <= cur_addr;
            ram_data_in <= wr_data;
            ram_rdn_wr  <= 1'b1;
            cur_addr    <= cur_addr + ADDR_WIDTH'(1);
            remaining   <= remaining - ADDR_WIDTH'(1);
          end
        end
        READ_ADDR: ram_addr <= cur_addr;
        READ_DATA: begin
          // First cycle in READ_DATA the RAM shows the addressed word; capture
          // it once and hold it until the consumer takes it.
          if (!rd_valid) begin
            rd_data  <= ram_data_out;
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            rd_valid  <= 1'b0;
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
